imm_encoder: RTL
================

# imm_encoder

Pipelined immediate packer: the inverse of the core's immediate extender. Takes a 32-bit immediate value, an immediate-format selector and a base instruction word, and inserts the immediate into the format-specific RV32 bit positions. Results go out through a valid/ready stream with an auto-incrementing write address, so the block can sit between the debug/patch loader and the instruction-memory write port. Out-of-range immediates are flagged, not silently truncated.

## Interface
- ADDR_W, 32: width of `out_addr`.
- BASE_ADDR, 0: `out_addr` value after reset or flush; must be word-aligned.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `flush` input 1: synchronous clear of pipeline and address.
- `in_valid` input 1: request valid.
- `in_ready` output 1: request accepted when `in_valid && in_ready`.
- `in_imm` input 32: immediate value, two's complement.
- `in_imm_src` input 3: format selector, using the shared immediate-source constants: IMM_I=0, IMM_S=1, IMM_B=2, IMM_J=3, IMM_U=4.
- `in_base` input 32: instruction word; its immediate-field bits are ignored.
- `out_valid` output 1: encoded word valid.
- `out_ready` input 1: sink accepts when `out_valid && out_ready`.
- `out_instr` output 32: encoded instruction.
- `out_err` output 1: range or format error for `out_instr`.
- `out_addr` output ADDR_W: write address of `out_instr`.
- `err_count` output 16: saturating count of errored outputs.

## Operation
- Stage 1 (S1) registers the request and computes `rng_ok`.
- Stage 2 (S2) registers the packed word, `out_err` and `out_addr`.
- Packing. Bits outside the listed fields come from `in_base`; listed fields are overwritten.
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5]; [11:7]=imm[4:0].
  - B: [31]=imm[12]; [30:25]=imm[10:5]; [11:8]=imm[4:1]; [7]=imm[11].
  - J: [31]=imm[20]; [30:21]=imm[10:1]; [20]=imm[11]; [19:12]=imm[19:12].
  - U: [31:12]=imm[31:12].
- Range rules:
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - U: imm[11:0]=0.
- Selector values 5–7 are always an error; the word passes through as `in_base` unchanged.
- On error, `out_err`=1 and the immediate fields are zero.
- `out_addr` starts at BASE_ADDR and increments by 4 on each output handshake, wrapping modulo 2^ADDR_W.
- `err_count` increments on each output handshake with `out_err`=1 and saturates at 0xFFFF.
- `flush` clears both stage valids and reloads `out_addr` to BASE_ADDR. `err_count` is kept.

## Timing
- Reset values: `out_valid`=0, `out_instr`=0, `out_err`=0, `out_addr`=BASE_ADDR, `err_count`=0. `in_ready` is 1 while both stages are empty.
- Latency: a request accepted at edge N appears on `out_*` after edge N+1 (two registers), provided `out_ready` is held high.
- Throughput: one word per cycle.
- Advance rules:
  - S2 loads when `!out_valid || out_ready`.
  - S1 advances when S2 loads.
  - `in_ready = !s1_valid || s2_load`.
- Backpressure: at most 2 words held. With `out_ready` low, `in_ready` falls once both stages are full. No drops, no reordering, and `out_*` stay stable while `out_valid && !out_ready`.
- `flush` together with a handshake: flush wins. The accepted input and the S1/S2 contents are discarded, and `out_addr` does not increment.
- Reset asserted mid-transfer: pipeline and outputs return to reset values immediately, without waiting for a clock edge.

## Configuration
- IMM_ENC_CHECK_EN defined: range rules are enforced as above.
- IMM_ENC_CHECK_EN undefined:
  - I/S/B/J/U always pass and are packed by truncation.
  - Only selector values 5–7 set `out_err`.
  - `err_count` counts only those.

## Test plan
- I-type: imm=0xFFFFFFFF, base=0x00000013 -> `out_instr`=0xFFF00013, err=0, addr=BASE_ADDR, two cycles after accept.
- B-type: imm=0xFFFFFFFE, base=0x00000063 -> 0xFE000FE3. J-type: imm=0x00000800, base=0x0000006F -> 0x0010006F, err=0.
- Range errors (macro on):
  - I imm=0x00000800, base=0x13 -> 0x00000013, err=1, `err_count`=1.
  - U imm=0x12345001 -> err=1. U imm=0x12345000, base=0x37 -> 0x12345037, err=0.
  - Macro off: I imm=0x00000800 -> 0x80000013, err=0.
- Backpressure: 4 back-to-back requests with `out_ready`=0 for 5 cycles -> `in_ready` low after 2 are held. After release, outputs arrive in order with addr BASE, +4, +8, +0xC and nothing is lost.
- Flush and reset: `flush` with 2 words in flight -> `out_valid`=0 next cycle and the next output uses addr=BASE_ADDR. `rst` pulse mid-stream -> all outputs at reset values immediately.

Source files
------------

// File: rtl/imm_encoder.sv
// Two-stage RV32 immediate packer with valid/ready output stream and auto-incrementing write address.
// Range checking is compiled in with IMM_ENC_CHECK_EN; without it only selectors 5-7 are errors.
module imm_encoder #(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_imm,
   input  logic [2:0]        in_imm_src,
   input  logic [31:0]       in_base,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic              out_err,
   output logic [ADDR_W-1:0] out_addr,
   output logic [15:0]       err_count
);

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_J = 3'd3;
   localparam logic [2:0] IMM_U = 3'd4;

   logic              s1_valid_q, s1_valid_d;
   logic [31:0]       s1_imm_q, s1_imm_d;
   logic [2:0]        s1_src_q, s1_src_d;
   logic [31:0]       s1_base_q, s1_base_d;
   logic              s1_rng_ok_q, s1_rng_ok_d;
   logic              out_valid_q, out_valid_d;
   logic [31:0]       out_instr_q, out_instr_d;
   logic              out_err_q, out_err_d;
   logic [ADDR_W-1:0] out_addr_q, out_addr_d;
   logic [15:0]       err_count_q, err_count_d;

   logic        s2_load, in_fire, out_fire, rng_ok, s1_err;
   logic [31:0] imm_k, packed_word;

   // Range check on the incoming request, registered alongside it in S1.
   always_comb begin
      rng_ok = 1'b0;
`ifdef IMM_ENC_CHECK_EN
      case (in_imm_src)
         IMM_I, IMM_S: rng_ok = (in_imm[31:11] == {21{in_imm[11]}});
         IMM_B:        rng_ok = (in_imm[31:12] == {20{in_imm[12]}}) && !in_imm[0];
         IMM_J:        rng_ok = (in_imm[31:20] == {12{in_imm[20]}}) && !in_imm[0];
         IMM_U:        rng_ok = (in_imm[11:0] == 12'd0);
         default:      rng_ok = 1'b0;
      endcase
`else
      rng_ok = (in_imm_src <= IMM_U);
`endif
   end

   // Errored words keep the base bits but carry zeroed immediate fields.
   always_comb begin
      s1_err      = !s1_rng_ok_q;
      imm_k       = s1_err ? 32'd0 : s1_imm_q;
      packed_word = s1_base_q;
      case (s1_src_q)
         IMM_I: packed_word[31:20] = imm_k[11:0];
         IMM_S: begin
            packed_word[31:25] = imm_k[11:5];
            packed_word[11:7]  = imm_k[4:0];
         end
         IMM_B: begin
            packed_word[31]    = imm_k[12];
            packed_word[30:25] = imm_k[10:5];
            packed_word[11:8]  = imm_k[4:1];
            packed_word[7]     = imm_k[11];
         end
         IMM_J: begin
            packed_word[31]    = imm_k[20];
            packed_word[30:21] = imm_k[10:1];
            packed_word[20]    = imm_k[11];
            packed_word[19:12] = imm_k[19:12];
         end
         IMM_U:   packed_word[31:12] = imm_k[31:12];
         default: packed_word = s1_base_q;
      endcase
   end

   always_comb begin
      s2_load  = !out_valid_q || out_ready;
      in_ready = !s1_valid_q || s2_load;
      in_fire  = in_valid && in_ready;
      out_fire = out_valid_q && out_ready;

      s1_valid_d  = s1_valid_q;
      s1_imm_d    = s1_imm_q;
      s1_src_d    = s1_src_q;
      s1_base_d   = s1_base_q;
      s1_rng_ok_d = s1_rng_ok_q;
      if (in_fire) begin
         s1_valid_d  = 1'b1;
         s1_imm_d    = in_imm;
         s1_src_d    = in_imm_src;
         s1_base_d   = in_base;
         s1_rng_ok_d = rng_ok;
      end else if (s2_load) begin
         s1_valid_d = 1'b0;
      end

      out_valid_d = out_valid_q;
      out_instr_d = out_instr_q;
      out_err_d   = out_err_q;
      if (s2_load) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            out_instr_d = packed_word;
            out_err_d   = s1_err;
         end
      end

      out_addr_d  = out_fire ? out_addr_q + ADDR_W'(4) : out_addr_q;
      err_count_d = err_count_q;
      if (out_fire && out_err_q && err_count_q != 16'hFFFF)
         err_count_d = err_count_q + 16'd1;

      // Flush discards everything in flight, including a same-cycle handshake.
      if (flush) begin
         s1_valid_d  = 1'b0;
         out_valid_d = 1'b0;
         out_addr_d  = BASE_ADDR;
         err_count_d = err_count_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_imm_q    <= '0;
         s1_src_q    <= '0;
         s1_base_q   <= '0;
         s1_rng_ok_q <= 1'b0;
         out_valid_q <= 1'b0;
         out_instr_q <= '0;
         out_err_q   <= 1'b0;
         out_addr_q  <= BASE_ADDR;
         err_count_q <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_imm_q    <= s1_imm_d;
         s1_src_q    <= s1_src_d;
         s1_base_q   <= s1_base_d;
         s1_rng_ok_q <= s1_rng_ok_d;
         out_valid_q <= out_valid_d;
         out_instr_q <= out_instr_d;
         out_err_q   <= out_err_d;
         out_addr_q  <= out_addr_d;
         err_count_q <= err_count_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_instr = out_instr_q;
   assign out_err   = out_err_q;
   assign out_addr  = out_addr_q;
   assign err_count = err_count_q;

endmodule
